// File: rtl/tcu_reg_wr_arb_pkg.sv
// Shared TCU register-write parameters: default sizes, requester indices
// and a small width helper used by the arbiter blocks.
package tcu_reg_wr_arb_pkg;

   localparam int TCU_NUM_REQ           = 4;
   localparam int TCU_REG_ADDR_SIZE_DEF = 12;
   localparam int TCU_REG_DATA_SIZE_DEF = 64;

   // Requester slots on the register write port.
   localparam int TCU_REQ_IDX_EXT_INVEP = 0;
   localparam int TCU_REQ_IDX_CTRL      = 1;
   localparam int TCU_REQ_IDX_DMA       = 2;
   localparam int TCU_REQ_IDX_CFG       = 3;

   // Index width that never collapses to zero bits.
   function automatic int tcu_idx_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tcu_rr_arbiter.sv
// Round-robin grant: first asserted request at or after ptr, ascending
// with wrap. Produces a one-hot grant and its binary index.
module tcu_rr_arbiter
   import tcu_reg_wr_arb_pkg::*;
#(
   parameter int N     = TCU_NUM_REQ,
   parameter int IDX_W = tcu_idx_width(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx
);

   int   idx;
   logic found;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/tcu_reg_wr_arb.sv
// Register-file write arbiter: round-robin among NUM_REQ requesters into a
// one-entry output buffer that can accept and drain in the same cycle.
module tcu_reg_wr_arb
   import tcu_reg_wr_arb_pkg::*;
#(
   parameter int NUM_REQ           = TCU_NUM_REQ,
   parameter int TCU_REG_ADDR_SIZE = TCU_REG_ADDR_SIZE_DEF,
   parameter int TCU_REG_DATA_SIZE = TCU_REG_DATA_SIZE_DEF
) (
   input  logic                                   clk_i,
   input  logic                                   reset_i,
   input  logic [NUM_REQ-1:0]                     req_en_i,
   input  logic [NUM_REQ*TCU_REG_ADDR_SIZE-1:0]   req_addr_i,
   input  logic [NUM_REQ*TCU_REG_DATA_SIZE-1:0]   req_wdata_i,
   output logic [NUM_REQ-1:0]                     req_stall_o,
   output logic                                   reg_en_o,
   output logic [TCU_REG_ADDR_SIZE-1:0]           reg_addr_o,
   output logic [TCU_REG_DATA_SIZE-1:0]           reg_wdata_o,
   input  logic                                   reg_stall_i,
   output logic [15:0]                            wr_count_o
);

   localparam int IDX_W = tcu_idx_width(NUM_REQ);

   // Handshakes: upstream, en is held until a cycle with en=1 and stall=0
   // (transfer). Downstream, reg_en_o is held with stable addr/data until a
   // cycle with reg_en_o=1 and reg_stall_i=0 (transfer).

   logic                         valid_q;
   logic [TCU_REG_ADDR_SIZE-1:0] addr_q;
   logic [TCU_REG_DATA_SIZE-1:0] data_q;
   logic [IDX_W-1:0]             rr_ptr_q;
   logic [15:0]                  wr_count_q;

   logic [NUM_REQ-1:0] grant;
   logic [IDX_W-1:0]   grant_idx;
   logic               consume;
   logic               buf_free;
   logic               accept;
   logic [IDX_W-1:0]   rr_ptr_nxt;

   tcu_rr_arbiter #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_rr_arbiter (
      .req       (req_en_i),
      .ptr       (rr_ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // reset_i gates accept so nothing is acknowledged while flops are held.
   assign consume     = valid_q && !reg_stall_i;
   assign buf_free    = !valid_q || consume;
   assign accept      = buf_free && (|req_en_i) && !reset_i;
   assign req_stall_o = req_en_i & ~(accept ? grant : '0);
   assign rr_ptr_nxt  = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         valid_q    <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         rr_ptr_q   <= '0;
         wr_count_q <= '0;
      end else begin
         if (accept) begin
            valid_q  <= 1'b1;
            addr_q   <= req_addr_i[int'(grant_idx)*TCU_REG_ADDR_SIZE +: TCU_REG_ADDR_SIZE];
            data_q   <= req_wdata_i[int'(grant_idx)*TCU_REG_DATA_SIZE +: TCU_REG_DATA_SIZE];
            rr_ptr_q <= rr_ptr_nxt;
         end else if (consume) begin
            // Drained buffer reads as zero on the address/data bus.
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
         end
         if (consume) begin
            wr_count_q <= wr_count_q + 16'd1;
         end
      end
   end

   assign reg_en_o    = valid_q;
   assign reg_addr_o  = valid_q ? addr_q : '0;
   assign reg_wdata_o = valid_q ? data_q : '0;
   assign wr_count_o  = wr_count_q;

endmodule

// File: doc/tcu_reg_wr_arb.md
TCU_REG_WR_ARB -- requirements
Module: tcu_reg_wr_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, number of write requesters (controller units such as the ext invep unit); legal range 2..8.
REQ-002 Parameter TCU_REG_ADDR_SIZE, default from tcu_parameter.vh, register address width.
REQ-003 Parameter TCU_REG_DATA_SIZE, default from tcu_parameter.vh, register data width (64).
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_i  input  1  reset, asynchronous and active-high.
REQ-006 req_en_i  input  NUM_REQ  per-requester write request; held until accepted.
REQ-007 req_addr_i  input  NUM_REQ*TCU_REG_ADDR_SIZE  packed addresses; slice i belongs to requester i.
REQ-008 req_wdata_i  input  NUM_REQ*TCU_REG_DATA_SIZE  packed write data; slice i belongs to requester i.
REQ-009 req_stall_o  output  NUM_REQ  per-requester stall; en=1 with stall=0 in a cycle means accepted.
REQ-010 reg_en_o  output  1  write strobe to the register file.
REQ-011 reg_addr_o  output  TCU_REG_ADDR_SIZE  register file write address.
REQ-012 reg_wdata_o  output  TCU_REG_DATA_SIZE  register file write data.
REQ-013 reg_stall_i  input  1  register file busy; write is consumed in a cycle with reg_en_o=1 and reg_stall_i=0.
REQ-014 wr_count_o  output  16  number of writes consumed by the register file since reset.

Function
REQ-015 One-entry output buffer (valid, addr, data) drives reg_en_o/reg_addr_o/reg_wdata_o directly; reg_en_o = buffer valid.
REQ-016 Buffer "free" this cycle = !valid OR (valid AND !reg_stall_i).
REQ-017 Arbitration: round-robin among asserted req_en_i bits, search starting at rr_ptr, then ascending index with wrap.
REQ-018 Accept = free AND any req_en_i; accepted requester gets req_stall_o[i]=0 combinationally in that cycle.
REQ-019 req_stall_o[i] = req_en_i[i] AND NOT(accept AND grant==i); requesters not requesting see stall=0.
REQ-020 On accept: buffer loads granted addr/data next edge, valid=1; rr_ptr = (grant+1) mod NUM_REQ.
REQ-021 Consume without accept: valid clears next edge; consume with accept in same cycle: buffer reloads, valid stays 1 (back-to-back, one write per cycle).
REQ-022 Latency: accepted request appears on reg_en_o exactly 1 cycle after acceptance.
REQ-023 No request is dropped or duplicated; requester i accepted at most once per en assertion cycle.
REQ-024 While reg_stall_i=1 and valid=1, buffer contents and outputs hold stable; all req_stall_o of requesting units = 1.
REQ-025 wr_count_o increments by 1 per consumed write, wraps 0xFFFF -> 0x0000.
REQ-026 Starvation bound: a continuously requesting unit is accepted within NUM_REQ accept cycles.
REQ-027 reg_addr_o/reg_wdata_o are zero whenever valid=0.

Reset
REQ-028 reset_i=1 asynchronously clears valid, buffer addr/data, rr_ptr (to 0) and wr_count_o; outputs: reg_en_o=0, reg_addr_o=0, reg_wdata_o=0, wr_count_o=0.
REQ-029 During reset req_stall_o[i] = req_en_i[i] (nothing accepted); a buffered write pending at reset is discarded.
REQ-030 First accept is possible in the first clock edge after reset_i deasserts.

Structure
REQ-031 NUM_REQ default and requester index constants (e.g. index of the ext invep unit) belong in the shared tcu parameter package.
REQ-032 The round-robin grant is one sub-module, tcu_rr_arbiter (inputs req vector and pointer, outputs one-hot grant and index).

Verification
REQ-033 Single req 0, addr 0x40, data 0x1234, reg_stall_i=0 -> req_stall_o[0]=0 same cycle; next cycle reg_en_o=1, addr 0x40, data 0x1234; wr_count_o=1.
REQ-034 Req 0..3 all asserted continuously, no stall -> accepts in order 0,1,2,3,0, one per cycle; wr_count_o=4 after 5 cycles.
REQ-035 Buffer valid, reg_stall_i=1 for 3 cycles with req 2 pending -> outputs stable, req_stall_o[2]=1 for 3 cycles; cycle stall drops: consume and accept req 2 simultaneously.
REQ-036 rr_ptr=3, req 1 and 3 asserted -> 3 granted first, then 1.
REQ-037 reset_i pulsed asynchronously mid-cycle with valid=1 -> reg_en_o=0 immediately, wr_count_o=0, write never consumed.
REQ-038 wr_count_o preloaded to 0xFFFF via 65535 writes, one more consume -> 0x0000.
